control_segmentado: RTL

- Next-generation main control unit for the 5-stage segmented MIPS core.
- Decodes the 6-bit opcode in ID and carries the control word through ID/EX, EX/MEM and MEM/WB control registers.
- Adds load-use hazard detection (stall + bubble), taken-branch flush, global pipeline enable, addi support and illegal-opcode flagging.
- Sits beside the datapath pipeline registers; stall and flush also drive PC and IF/ID write/clear.

---
 rtl/control_pkg.sv | 31 +++
 rtl/control_deco.sv | 44 ++++
 rtl/control_segmentado.sv | 85 ++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared opcodes, ALUOp codes and control-word layout for the segmented MIPS control unit.
package control_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    // MEM and WB fields sit in the low bits so later stages keep a contiguous slice.
    localparam int CTRL_W      = 9;
    localparam int C_REGDEST   = 8;
    localparam int C_FUENTEALU = 7;
    localparam int C_ALUOP_HI  = 6;
    localparam int C_ALUOP_LO  = 5;
    localparam int C_SALTOCOND = 4;
    localparam int C_LEERMEM   = 3;
    localparam int C_ESCRMEM   = 2;
    localparam int C_MEMAREG   = 1;
    localparam int C_ESCRREG   = 0;

    localparam int MEM_W = C_SALTOCOND + 1;
    localparam int WB_W  = C_MEMAREG + 1;

    typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/control_deco.sv
// Combinational ID-stage opcode decoder: control word plus illegal-opcode flag.
module control_deco
    import control_pkg::*;
(
    input  logic [5:0] i_instru,
    output ctrl_t      o_ctrl,
    output logic       o_ilegal
);

    always_comb begin
        o_ctrl   = '0;
        o_ilegal = 1'b0;
        case (i_instru)
            OP_R: begin
                o_ctrl[C_REGDEST]              = 1'b1;
                o_ctrl[C_ESCRREG]              = 1'b1;
                o_ctrl[C_ALUOP_HI:C_ALUOP_LO]  = ALU_FUNC;
            end
            OP_LW: begin
                o_ctrl[C_FUENTEALU]            = 1'b1;
                o_ctrl[C_LEERMEM]              = 1'b1;
                o_ctrl[C_MEMAREG]              = 1'b1;
                o_ctrl[C_ESCRREG]              = 1'b1;
                o_ctrl[C_ALUOP_HI:C_ALUOP_LO]  = ALU_ADD;
            end
            OP_SW: begin
                o_ctrl[C_FUENTEALU]            = 1'b1;
                o_ctrl[C_ESCRMEM]              = 1'b1;
                o_ctrl[C_ALUOP_HI:C_ALUOP_LO]  = ALU_ADD;
            end
            OP_BEQ: begin
                o_ctrl[C_SALTOCOND]            = 1'b1;
                o_ctrl[C_ALUOP_HI:C_ALUOP_LO]  = ALU_SUB;
            end
            OP_ADDI: begin
                o_ctrl[C_FUENTEALU]            = 1'b1;
                o_ctrl[C_ESCRREG]              = 1'b1;
                o_ctrl[C_ALUOP_HI:C_ALUOP_LO]  = ALU_ADD;
            end
            default: o_ilegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_segmentado.sv
// Pipelined main control: ID decode carried through ID/EX, EX/MEM, MEM/WB with load-use stall and branch flush.
module control_segmentado
    import control_pkg::*;
#(
    parameter int RW     = 5,
    parameter bit HAZ_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [5:0]    instru,
    input  logic [RW-1:0] rs_id,
    input  logic [RW-1:0] rt_id,
    input  logic          salto_tomado,
    output logic          stall,
    output logic          flush,
    output logic          ex_RegDest,
    output logic          ex_FuenteALU,
    output logic [1:0]    ex_ALUOp,
    output logic          ex_ilegal,
    output logic          mem_SaltoCond,
    output logic          mem_LeerMem,
    output logic          mem_EscrMem,
    output logic          wb_MemaReg,
    output logic          wb_EscrReg
);

    ctrl_t             w_ctrl;
    logic              w_ilegal;
    logic              w_stall;
    logic              w_flush;

    ctrl_t             r_idex_ctrl;
    logic              r_idex_ilegal;
    logic [RW-1:0]     r_idex_rt;
    logic [MEM_W-1:0]  r_exmem;
    logic [WB_W-1:0]   r_memwb;

    control_deco u_deco (
        .i_instru (instru),
        .o_ctrl   (w_ctrl),
        .o_ilegal (w_ilegal)
    );

    // A taken branch squashes the dependent instruction anyway, so it suppresses the stall.
    assign w_flush = salto_tomado;
    assign w_stall = HAZ_EN && r_idex_ctrl[C_LEERMEM] && (r_idex_rt != '0)
                     && ((r_idex_rt == rs_id) || (r_idex_rt == rt_id)) && !salto_tomado;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idex_ctrl   <= '0;
            r_idex_ilegal <= 1'b0;
            r_idex_rt     <= '0;
            r_exmem       <= '0;
            r_memwb       <= '0;
        end else if (en) begin
            if (w_flush || w_stall) begin
                r_idex_ctrl   <= '0;
                r_idex_ilegal <= 1'b0;
                r_idex_rt     <= '0;
            end else begin
                r_idex_ctrl   <= w_ctrl;
                r_idex_ilegal <= w_ilegal;
                r_idex_rt     <= rt_id;
            end
            r_exmem <= w_flush ? '0 : r_idex_ctrl[MEM_W-1:0];
            // The branch itself keeps flowing into WB.
            r_memwb <= r_exmem[WB_W-1:0];
        end
    end

    assign stall         = w_stall;
    assign flush         = w_flush;
    assign ex_RegDest    = r_idex_ctrl[C_REGDEST];
    assign ex_FuenteALU  = r_idex_ctrl[C_FUENTEALU];
    assign ex_ALUOp      = r_idex_ctrl[C_ALUOP_HI:C_ALUOP_LO];
    assign ex_ilegal     = r_idex_ilegal;
    assign mem_SaltoCond = r_exmem[C_SALTOCOND];
    assign mem_LeerMem   = r_exmem[C_LEERMEM];
    assign mem_EscrMem   = r_exmem[C_ESCRMEM];
    assign wb_MemaReg    = r_memwb[C_MEMAREG];
    assign wb_EscrReg    = r_memwb[C_ESCRREG];

endmodule
